// File: rtl/serial_frame_deser_pkg.sv
// rtl/serial_frame_deser_pkg.sv - shared state encodings, default parameters and helpers for serial_frame_deser
package serial_frame_deser_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam int         DEF_WIDTH         = 4;
  localparam logic [3:0] DEF_SYNC          = 4'b0011;
  localparam int         DEF_PAYLOAD_WORDS = 2;
  localparam int         DEF_MISS_MAX      = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/serial_frame_deser_if.sv
// rtl/serial_frame_deser_if.sv - serial input and word output bundle; STATS_EN adds frame/miss counters
interface serial_frame_deser_if
  import serial_frame_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             bit_in;
  logic             bit_en;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             locked;
  logic             overflow;
`ifdef STATS_EN
  logic [7:0]       frame_cnt;
  logic [7:0]       miss_total;

  modport master (
    input  bit_in, bit_en, data_ready,
    output data_out, data_valid, locked, overflow, frame_cnt, miss_total
  );
  modport slave (
    output bit_in, bit_en, data_ready,
    input  data_out, data_valid, locked, overflow, frame_cnt, miss_total
  );
`else
  modport master (
    input  bit_in, bit_en, data_ready,
    output data_out, data_valid, locked, overflow
  );
  modport slave (
    output bit_in, bit_en, data_ready,
    input  data_out, data_valid, locked, overflow
  );
`endif

endinterface

// File: rtl/serial_frame_deser_fifo2.sv
// rtl/serial_frame_deser_fifo2.sv - two-entry word buffer with dropped-push indication
module serial_deser_fifo2
  import serial_frame_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       cnt_q;
  logic             pop_ok;

  assign pop_ok  = pop_i && (cnt_q != 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign head_o  = head_q;
  // A push into a full buffer survives only when the head leaves on the same edge.
  assign drop_o  = push_i && full_o && !pop_ok;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      unique case ({push_i, pop_ok})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_q <= din_i;
            cnt_q  <= 2'd1;
          end else if (cnt_q == 2'd1) begin
            tail_q <= din_i;
            cnt_q  <= 2'd2;
          end
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= din_i;
          end else begin
            head_q <= tail_q;
            tail_q <= din_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/serial_frame_deser.sv
// rtl/serial_frame_deser.sv - sync hunt, frame deserializer and lock tracker; STATS_EN adds frame/miss counters
module serial_frame_deser
  import serial_frame_deser_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC          = WIDTH'(DEF_SYNC),
  parameter int               PAYLOAD_WORDS = DEF_PAYLOAD_WORDS,
  parameter int               MISS_MAX      = DEF_MISS_MAX
) (
  input  logic                  clk,
  input  logic                  clr,
  serial_frame_deser_if.master  bus
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL_FILL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [7:0]    LAST_WORD = 8'(PAYLOAD_WORDS - 1);
  localparam logic [3:0]    MISS_LIM  = 4'(MISS_MAX);

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [CW-1:0]    fill_q;
  logic [CW-1:0]    fill_d;
  logic [CW-1:0]    bit_cnt_q;
  logic [7:0]       word_cnt_q;
  logic [3:0]       miss_cnt_q;
  logic [3:0]       miss_d;
  logic             locked_q;
  logic             overflow_q;
`ifdef STATS_EN
  logic [7:0]       frame_cnt_q;
  logic [7:0]       miss_total_q;
`endif

  logic             hunt_match;
  logic             word_done;
  logic             sync_ok;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;

  always_comb begin
    sreg_d     = {sreg_q[WIDTH-2:0], bus.bit_in};
    fill_d     = (fill_q == FULL_FILL) ? fill_q : fill_q + CW'(1);
    // The fill count keeps reset zeros and pre-hunt bits from forming a false sync.
    hunt_match = (state_q == ST_HUNT) && (fill_d == FULL_FILL) && (sreg_d == SYNC);
    word_done  = (state_q != ST_HUNT) && (bit_cnt_q == LAST_BIT);
    sync_ok    = (sreg_d == SYNC);
    miss_d     = miss_cnt_q + 4'd1;
    push       = bus.bit_en && word_done && (state_q == ST_DATA);
    pop        = bus.data_ready && !fifo_empty;
  end

  serial_deser_fifo2 #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push_i  (push),
    .din_i   (sreg_d),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  always @(posedge clk) begin
    if (!clr) begin
      assert (!fifo_drop || fifo_full);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= ST_HUNT;
      sreg_q       <= '0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= 8'd0;
      miss_cnt_q   <= 4'd0;
      locked_q     <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef STATS_EN
      frame_cnt_q  <= 8'd0;
      miss_total_q <= 8'd0;
`endif
    end else begin
      if (fifo_drop) begin
        overflow_q <= 1'b1;
      end
      if (bus.bit_en) begin
        sreg_q <= sreg_d;
        unique case (state_q)
          ST_HUNT: begin
            fill_q <= fill_d;
            if (hunt_match) begin
              state_q    <= ST_DATA;
              bit_cnt_q  <= '0;
              word_cnt_q <= 8'd0;
              miss_cnt_q <= 4'd0;
              locked_q   <= 1'b1;
`ifdef STATS_EN
              frame_cnt_q <= sat_inc8(frame_cnt_q);
`endif
            end
          end
          ST_DATA: begin
            if (word_done) begin
              bit_cnt_q <= '0;
              if (word_cnt_q == LAST_WORD) begin
                state_q    <= ST_CHECK;
                word_cnt_q <= 8'd0;
              end else begin
                word_cnt_q <= word_cnt_q + 8'd1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
          ST_CHECK: begin
            if (word_done) begin
              bit_cnt_q <= '0;
              if (sync_ok) begin
                miss_cnt_q <= 4'd0;
                state_q    <= ST_DATA;
`ifdef STATS_EN
                frame_cnt_q <= sat_inc8(frame_cnt_q);
`endif
              end else begin
                miss_cnt_q <= miss_d;
`ifdef STATS_EN
                miss_total_q <= sat_inc8(miss_total_q);
`endif
                // Below the miss limit the frame is still trusted and delivered.
                if (miss_d == MISS_LIM) begin
                  state_q  <= ST_HUNT;
                  fill_q   <= '0;
                  locked_q <= 1'b0;
                end else begin
                  state_q <= ST_DATA;
                end
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= ST_HUNT;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = fifo_head;
  assign bus.data_valid = !fifo_empty;
  assign bus.locked     = locked_q;
  assign bus.overflow   = overflow_q;
`ifdef STATS_EN
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.miss_total = miss_total_q;
`endif

endmodule
